// File: rtl/sub_rst_ctrl.sv
// rtl/sub_rst_ctrl.sv - fault-triggered isolate/drain/reset/release sequencer for one subordinate
module sub_rst_ctrl #(
  parameter int CntWidth      = 16,
  parameter int FaultCntWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     fault_i,
  input  logic                     outstanding_i,
  input  logic [CntWidth-1:0]      drain_budget_i,
  input  logic [CntWidth-1:0]      hold_cycles_i,
  input  logic [CntWidth-1:0]      ack_budget_i,
  input  logic                     rst_stat_i,
  input  logic                     irq_clr_i,
  output logic                     isolate_o,
  output logic                     rst_req_o,
  output logic                     irq_o,
  output logic                     err_o,
  output logic                     busy_o,
  output logic [FaultCntWidth-1:0] fault_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_RESET,
    ST_RELEASE,
    ST_NOTIFY,
    ST_ERROR
  } state_t;

  state_t                   r_state;
  logic [CntWidth-1:0]      r_cnt;
  logic [CntWidth-1:0]      r_ack;
  logic                     r_stat_seen;
  logic [FaultCntWidth-1:0] r_fault_cnt;

  logic w_cnt_zero;
  logic w_hold_done;
  logic w_ack_last;
  logic w_stat_ok;
  logic w_fault_sat;

  // Hold and ack windows end on the cycle the counter would reach zero, so a
  // budget of N gives N cycles and a budget of 0 behaves like 1.
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_hold_done = (r_cnt <= CntWidth'(1));
  assign w_ack_last  = (r_ack <= CntWidth'(1));
  assign w_stat_ok   = r_stat_seen | rst_stat_i;
  assign w_fault_sat = &r_fault_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ack       <= '0;
      r_stat_seen <= 1'b0;
      r_fault_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (fault_i) begin
            r_state <= ST_DRAIN;
            r_cnt   <= drain_budget_i;
            if (!w_fault_sat) r_fault_cnt <= r_fault_cnt + FaultCntWidth'(1);
          end
        end
        ST_DRAIN: begin
          if (!outstanding_i || w_cnt_zero) begin
            r_state     <= ST_RESET;
            r_cnt       <= hold_cycles_i;
            r_ack       <= ack_budget_i;
            r_stat_seen <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CntWidth'(1);
          end
        end
        ST_RESET: begin
          if (!w_cnt_zero) r_cnt <= r_cnt - CntWidth'(1);
          if (rst_stat_i) r_stat_seen <= 1'b1;
          // Once the subordinate has acknowledged, only the hold time matters.
          if (w_hold_done && w_stat_ok) begin
            r_state <= ST_RELEASE;
            r_ack   <= ack_budget_i;
          end else if (!w_stat_ok) begin
            if (w_ack_last) r_state <= ST_ERROR;
            else            r_ack   <= r_ack - CntWidth'(1);
          end
        end
        ST_RELEASE: begin
          if (!rst_stat_i)     r_state <= ST_NOTIFY;
          else if (w_ack_last) r_state <= ST_ERROR;
          else                 r_ack   <= r_ack - CntWidth'(1);
        end
        ST_NOTIFY: begin
          if (irq_clr_i) r_state <= ST_IDLE;
        end
        ST_ERROR: begin
          r_state <= ST_ERROR;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign isolate_o   = (r_state == ST_DRAIN) || (r_state == ST_RESET) ||
                       (r_state == ST_RELEASE) || (r_state == ST_ERROR);
  assign rst_req_o   = (r_state == ST_RESET);
  assign irq_o       = (r_state == ST_NOTIFY) || (r_state == ST_ERROR);
  assign err_o       = (r_state == ST_ERROR);
  assign busy_o      = (r_state != ST_IDLE);
  assign fault_cnt_o = r_fault_cnt;

endmodule
